// File: rtl/jt5205_adpcm_dec_if.sv
// -----------------------------------------------------------------------------
// jt5205_adpcm_dec_if
//
// Purpose:
//   Bundles the sample-side signals of the MSM5205 ADPCM decoder stage: the
//   strobe and code coming from the timing / data-feed side, and the decoded
//   sample going out to the mixer.
//
// Signals:
//   cen_lo     1   sample strobe, one clk cycle wide
//   dec_rst    1   chip RESET pin, synchronous, active-high
//   din        4   ADPCM code: din[3] = sign, din[2:0] = magnitude
//   sound      12  signed decoded sample, two's complement
//   sample_ok  1   one-cycle pulse when sound has just been updated
//
// Modports:
//   master  - drives strobe/reset/code, observes the decoded sample
//   slave   - the decoder itself
// -----------------------------------------------------------------------------
interface jt5205_adpcm_dec_if;
   logic               cen_lo;
   logic               dec_rst;
   logic        [3:0]  din;
   logic signed [11:0] sound;
   logic               sample_ok;

   modport master (
      output cen_lo,
      output dec_rst,
      output din,
      input  sound,
      input  sample_ok
   );

   modport slave (
      input  cen_lo,
      input  dec_rst,
      input  din,
      output sound,
      output sample_ok
   );
endinterface : jt5205_adpcm_dec_if

// File: rtl/jt5205_adpcm_dec.sv
// -----------------------------------------------------------------------------
// jt5205_adpcm_dec
//
// Purpose:
//   OKI/MSM5205 4-bit ADPCM decoder stage. Each cen_lo strobe consumes one
//   4-bit code, advances the step-table index and updates a 12-bit signed
//   accumulator which is presented on sound.
//
//   Two-stage pipeline:
//     stage 1 (cen_lo=1) : latch code and step(idx), advance idx
//     stage 2 (r_v1=1)   : build diff from the latched step, update acc
//   Both stages run concurrently, so back-to-back strobes are accepted with
//   no stall; stage 1 always reads the index already updated by the
//   previous strobe.
//
// Parameters:
//   IDX_INIT  step-table index loaded on rst_n and dec_rst (0..48)
//   SAT       1: accumulator saturates to -2048..2047; 0: wraps modulo 2^12
//
// Ports:
//   clk       system clock, all state changes on posedge
//   rst_n     asynchronous active-low reset
//   bus       slave side of jt5205_adpcm_dec_if (cen_lo, dec_rst, din in;
//             sound, sample_ok out)
// -----------------------------------------------------------------------------
module jt5205_adpcm_dec #(
   parameter int IDX_INIT = 0,
   parameter bit SAT      = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   jt5205_adpcm_dec_if.slave       bus
);

   localparam logic        [5:0]  IDX_RST = 6'(IDX_INIT);
   localparam logic        [5:0]  IDX_MAX = 6'd48;
   localparam logic signed [11:0] ACC_MAX = 12'sh7FF;
   localparam logic signed [11:0] ACC_MIN = 12'sh800;

   // --------------------------------------------------------------------------
   // Step table: floor(16 * 1.1^n), n = 0..48. Entries never exceed 11 bits,
   // the ROM is kept 16 bits wide to match the original chip table.
   // --------------------------------------------------------------------------
   function automatic logic [15:0] f_step(input logic [5:0] n);
      logic [15:0] s;
      case (n)
         6'd0 : s = 16'd16;    6'd1 : s = 16'd17;    6'd2 : s = 16'd19;
         6'd3 : s = 16'd21;    6'd4 : s = 16'd23;    6'd5 : s = 16'd25;
         6'd6 : s = 16'd28;    6'd7 : s = 16'd31;    6'd8 : s = 16'd34;
         6'd9 : s = 16'd37;    6'd10: s = 16'd41;    6'd11: s = 16'd45;
         6'd12: s = 16'd50;    6'd13: s = 16'd55;    6'd14: s = 16'd60;
         6'd15: s = 16'd66;    6'd16: s = 16'd73;    6'd17: s = 16'd80;
         6'd18: s = 16'd88;    6'd19: s = 16'd97;    6'd20: s = 16'd107;
         6'd21: s = 16'd118;   6'd22: s = 16'd130;   6'd23: s = 16'd143;
         6'd24: s = 16'd157;   6'd25: s = 16'd173;   6'd26: s = 16'd190;
         6'd27: s = 16'd209;   6'd28: s = 16'd230;   6'd29: s = 16'd253;
         6'd30: s = 16'd279;   6'd31: s = 16'd307;   6'd32: s = 16'd337;
         6'd33: s = 16'd371;   6'd34: s = 16'd408;   6'd35: s = 16'd449;
         6'd36: s = 16'd494;   6'd37: s = 16'd544;   6'd38: s = 16'd598;
         6'd39: s = 16'd658;   6'd40: s = 16'd724;   6'd41: s = 16'd796;
         6'd42: s = 16'd876;   6'd43: s = 16'd963;   6'd44: s = 16'd1060;
         6'd45: s = 16'd1166;  6'd46: s = 16'd1282;  6'd47: s = 16'd1411;
         // Indices above 48 are unreachable because idx is clamped; they
         // alias to the last entry so the ROM has no undefined outputs.
         default: s = 16'd1552;
      endcase
      return s;
   endfunction

   // --------------------------------------------------------------------------
   // Index adjust by magnitude: 0..3 -> -1, 4..7 -> +2,+4,+6,+8.
   // For magnitudes 4..7 the adjust is 2 + 2*mag[1:0]. The result is
   // clamped to 0..48 regardless of SAT.
   // --------------------------------------------------------------------------
   function automatic logic [5:0] f_idx_next(input logic [5:0] idx,
                                             input logic [2:0] mag);
      logic signed [7:0] adj;
      logic signed [7:0] sum;
      adj = mag[2] ? (8'sd2 + $signed({5'd0, mag[1:0], 1'b0})) : -8'sd1;
      sum = $signed({2'b00, idx}) + adj;
      if (sum < 8'sd0)
         return 6'd0;
      else if (sum > 8'sd48)
         return IDX_MAX;
      else
         return sum[5:0];
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic        [5:0]  r_idx;     // step-table index
   logic        [3:0]  r_code;    // stage-1 latched code
   logic        [15:0] r_step;    // stage-1 latched step(idx)
   logic               r_v1;      // stage-1 holds a sample for stage 2
   logic signed [11:0] r_acc;     // accumulator, also the visible sample
   logic               r_ok;      // sample_ok pulse

   // --------------------------------------------------------------------------
   // Stage-2 datapath
   // --------------------------------------------------------------------------
   logic        [15:0] w_diff;
   logic signed [17:0] w_acc_ext;
   logic signed [17:0] w_diff_ext;
   logic signed [17:0] w_sum;
   logic signed [11:0] w_acc_next;
   logic        [5:0]  w_idx_next;

   // diff = step/8 + step/4*b0 + step/2*b1 + step*b2; at most 2910, so it
   // fits the 13-bit range; the wider vector simply keeps the sum exact.
   assign w_diff = (r_step >> 3)
                 + (r_code[0] ? (r_step >> 2) : 16'd0)
                 + (r_code[1] ? (r_step >> 1) : 16'd0)
                 + (r_code[2] ?  r_step       : 16'd0);

   // The sum is formed wider than the 14 bits strictly needed; the value is
   // identical and saturation only has to look at one signed compare.
   assign w_acc_ext  = {{6{r_acc[11]}}, r_acc};
   assign w_diff_ext = $signed({2'b00, w_diff});
   assign w_sum      = r_code[3] ? (w_acc_ext - w_diff_ext)
                                 : (w_acc_ext + w_diff_ext);

   assign w_acc_next = !SAT                   ? w_sum[11:0]
                     : (w_sum > 18'sd2047)    ? ACC_MAX
                     : (w_sum < -18'sd2048)   ? ACC_MIN
                     :                          w_sum[11:0];

   assign w_idx_next = f_idx_next(r_idx, bus.din[2:0]);

   // --------------------------------------------------------------------------
   // Pipeline registers
   // --------------------------------------------------------------------------
   // NOTE: every register here uses non-blocking assignments so stage 2 sees
   // the stage-1 values from before this edge while stage 1 loads new ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the pipeline registers are plain flops, not a memory, so they
         // are cleared too; the step table is combinational and needs none.
         r_idx  <= IDX_RST;
         r_code <= 4'd0;
         r_step <= 16'd0;
         r_v1   <= 1'b0;
         r_acc  <= 12'sd0;
         r_ok   <= 1'b0;
      end else if (bus.dec_rst) begin
         // Chip RESET wins over a new strobe and over the sample in stage 2.
         r_idx  <= IDX_RST;
         r_v1   <= 1'b0;
         r_acc  <= 12'sd0;
         r_ok   <= 1'b0;
      end else begin
         // Stage 2
         r_ok <= r_v1;
         if (r_v1)
            r_acc <= w_acc_next;

         // Stage 1
         r_v1 <= bus.cen_lo;
         if (bus.cen_lo) begin
            r_code <= bus.din;
            r_step <= f_step(r_idx);
            r_idx  <= w_idx_next;
         end
      end
   end

   assign bus.sound     = r_acc;
   assign bus.sample_ok = r_ok;

endmodule : jt5205_adpcm_dec
